// File: rtl/tate_host_pkg.sv
// Shared state encoding and sizing helpers for the Tate pairing host interface.
package tate_host_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        UNLOAD = 3'd4
    } host_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int M_DEFAULT  = 97;
    localparam int DW_DEFAULT = 32;
    localparam int OPW        = ceil_div(2 * M_DEFAULT, DW_DEFAULT);
    localparam int RSW        = ceil_div(12 * M_DEFAULT, DW_DEFAULT);
    localparam int OP_IDX_W   = $clog2(4 * OPW);

endpackage

// File: rtl/tate_result_serializer.sv
// Captures the 12*M-bit pairing result and streams it out little-endian as DW-bit words.
module tate_result_serializer
    import tate_host_pkg::*;
#(
    parameter int M  = M_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [12*M-1:0] result,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            done
);

    localparam int RW    = 12 * M;
    localparam int RSW_L = ceil_div(RW, DW);
    localparam int J_W   = (RSW_L > 1) ? $clog2(RSW_L) : 1;

    logic [DW-1:0]  words [RSW_L];
    logic [J_W-1:0] j;

    // Each word keeps only the result bits it covers; the top word is zero-filled.
    genvar gi;
    generate
        for (gi = 0; gi < RSW_L; gi++) begin : g_word
            localparam int LO = gi * DW;
            localparam int W  = (RW - LO < DW) ? (RW - LO) : DW;
            logic [W-1:0] word_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (load) begin
                    word_reg <= result[LO +: W];
                end
            end

            assign words[gi] = DW'(word_reg);
        end
    endgenerate

    assign out_data = words[j];
    assign out_last = out_valid && (j == J_W'(RSW_L - 1));
    assign done     = out_valid && out_ready && out_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            j         <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            j         <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            j         <= '0;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                out_valid <= 1'b0;
                j         <= '0;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tate_pairing_host_if.sv
// Host-side initiator for tate_pairing: operand assembly, core sequencing, result return.
// Define TATE_HOST_CYCLE_CNT_EN to add the cycle_cnt output counting WAIT cycles.
module tate_pairing_host_if
    import tate_host_pkg::*;
#(
    parameter int M  = M_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            busy,
    output logic            core_rst,
    output logic [2*M-1:0]  core_x1,
    output logic [2*M-1:0]  core_y1,
    output logic [2*M-1:0]  core_x2,
    output logic [2*M-1:0]  core_y2,
    input  logic            core_done,
`ifdef TATE_HOST_CYCLE_CNT_EN
    output logic [31:0]     cycle_cnt,
`endif
    input  logic [12*M-1:0] core_out
);

    localparam int OPW_L  = ceil_div(2 * M, DW);
    localparam int NWORDS = 4 * OPW_L;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    host_state_t          state;
    logic [IDX_W-1:0]     widx;
    logic [3:0][2*M-1:0]  ops;
    logic                 op_wr;
    logic                 res_load;
    logic                 ser_done;

    assign op_wr    = in_valid && in_ready && !abort;
    assign res_load = (state == WAIT) && core_done && !abort;

    // Word k of operand n lands at bits [k*DW +: DW]; bits beyond 2*M are never stored.
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_op
            localparam int OP = gi / OPW_L;
            localparam int LO = (gi % OPW_L) * DW;
            localparam int W  = (2 * M - LO < DW) ? (2 * M - LO) : DW;
            logic [W-1:0] word_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (op_wr && (widx == IDX_W'(gi))) begin
                    word_reg <= in_data[W-1:0];
                end
            end

            assign ops[OP][LO +: W] = word_reg;
        end
    endgenerate

    assign core_x1 = ops[0];
    assign core_y1 = ops[1];
    assign core_x2 = ops[2];
    assign core_y2 = ops[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            widx     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            core_rst <= 1'b1;
        end else if (abort) begin
            state    <= IDLE;
            widx     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        state <= LOAD;
                        widx  <= widx + 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (widx == LAST_IDX) begin
                            state    <= START;
                            widx     <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end
                end
                // One settling cycle with the core still held in reset.
                START: begin
                    state    <= WAIT;
                    core_rst <= 1'b0;
                end
                WAIT: begin
                    if (core_done) begin
                        state    <= UNLOAD;
                        core_rst <= 1'b1;
                    end
                end
                UNLOAD: begin
                    if (ser_done) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    widx     <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

`ifdef TATE_HOST_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if ((state == LOAD) && op_wr && (widx == LAST_IDX)) begin
            cycle_cnt <= '0;
        end else if ((state == WAIT) && (cycle_cnt != 32'hFFFF_FFFF)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    tate_result_serializer #(
        .M  (M),
        .DW (DW)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (res_load),
        .clear     (abort),
        .result    (core_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (ser_done)
    );

endmodule

// File: doc/tate_pairing_host_if.md
Name: tate_pairing_host_if

Overview:
Host-side initiator for the Tate pairing core.
- Accepts the four operands x1, y1, x2, y2 as a stream of narrow words and assembles them into full F(3^m) element registers.
- Starts the core by releasing its active-high synchronous reset, waits for the core's done flag, and captures the 12*M-bit result.
- Returns the result to the host as a ready/valid word stream with a last-word marker. It sits between the system bus adapter and tate_pairing.

Parameters:
M, 97, field extension degree; operand width 2*M bits, result width 12*M bits.
DW, 32, host stream word width.
OPW, ceil(2*M/DW) = 7, derived: words per operand.
RSW, ceil(12*M/DW) = 37, derived: words per result.

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  host operand word valid
in_ready  out  1  block accepts an operand word
in_data  in  DW  operand word
abort  in  1  synchronous abort, returns the block to IDLE
out_valid  out  1  result word valid
out_ready  in  1  host accepts a result word
out_data  out  DW  result word
out_last  out  1  final result word
busy  out  1  high from the first accepted word until the last result word is accepted
core_rst  out  1  drives tate_pairing reset (active-high, synchronous on the core side)
core_x1, core_y1, core_x2, core_y2  out  2*M each  operand buses to the core
core_done  in  1  tate_pairing done
core_out  in  12*M  tate_pairing out

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - in_ready=0, out_valid=0, out_last=0, busy=0, core_rst=1.
  - out_data=0; operand and result registers = 0; word counters = 0.
- States IDLE, LOAD, START, WAIT, UNLOAD.
- IDLE:
  - in_ready=1. The first in_valid&in_ready handshake stores word 0 and goes to LOAD.
- LOAD:
  - Words arrive in operand order x1, y1, x2, y2; each operand takes OPW words.
  - Little-endian: word k fills bits [k*DW +: DW].
  - Bits above 2*M in an operand's last word are discarded.
  - in_ready=1 throughout. The handshake that accepts word 4*OPW-1 moves to START.
- START:
  - in_ready=0, core_rst=1 for exactly one cycle, so the operand buses are stable before the core is released.
  - Next cycle: WAIT.
- WAIT:
  - core_rst=0.
  - core_x1..core_y2 are held constant from START until the next return to IDLE.
  - On core_done=1, capture core_out into the result register, set core_rst=1 and go to UNLOAD.
  - core_done seen in any other state is ignored.
- UNLOAD:
  - out_valid=1. out_data = result word j (little-endian, upper bits of word RSW-1 zero-filled).
  - out_last=1 only when j=RSW-1.
  - j advances only on out_valid&out_ready. out_data stays stable while out_ready=0.
  - The handshake on the last word goes to IDLE.
- core_rst is 1 in every state except WAIT.
- abort=1 in any state:
  - next state IDLE; counters cleared; out_valid=0; core_rst=1.
  - Operand registers are not cleared.
  - abort takes priority over a same-cycle handshake, and that word is dropped.
- busy = (state != IDLE).
- Latency:
  - The last operand handshake is followed by 1 START cycle. core_rst falls at the edge after that.
  - out_valid rises in the cycle after core_done is sampled.

Optional Feature:
Macro TATE_HOST_CYCLE_CNT_EN.
- Defined:
  - Adds output cycle_cnt [31:0] (reset 0). It clears on entry to START and increments every WAIT cycle, saturating at 32'hFFFF_FFFF.
  - Its value is held through UNLOAD and IDLE until the next START.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package tate_host_pkg: state encoding constants (IDLE=0, LOAD=1, START=2, WAIT=3, UNLOAD=4), OPW/RSW computation, the operand-index width.
- One sub-module, tate_result_serializer: holds the 12*M result register, the word index j, and the out_valid/out_ready/out_last logic.
- The top level keeps the FSM and the operand assembly.

Test Plan:
- Load 28 words encoding x1=1, y1=2, x2=3, y2=4 with in_valid held high. Required: core_rst falls 29 cycles after the first handshake, and core_x1 = 194'd1.
- Stub core asserts core_done with core_out = bit i set at trit positions 0 and 1163. Required: 37 out words; word 0 = 32'h1, word 36 = 32'h800 with out_last=1, all others 0.
- Toggle out_ready pseudo-randomly during UNLOAD. Required: no word lost or duplicated, and out_data is stable whenever out_valid&!out_ready.
- Assert abort at word 10 of LOAD, then reload the full set. Required: the result matches a fresh load, and core_rst stays 1 throughout the abort.
- Assert reset=0 mid-WAIT. Required: immediate core_rst=1, busy=0, out_valid=0, state IDLE, with no dependence on clk.
- With TATE_HOST_CYCLE_CNT_EN, the stub takes 50 WAIT cycles. Required: cycle_cnt=50 during UNLOAD.
